// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch sequencer sitting in front of the PC register. Every cycle it produces
// the value the PC register loads (npc). It runs the request/grant/response
// handshake to instruction memory (one outstanding request at most). It holds
// the returned instruction for decode. It also arbitrates redirects
// (trap > jump > branch) against sequential fetch. A redirect that arrives
// while a fetch is in flight marks that fetch as killed, so its response is
// dropped when it drains.
//
// Configuration macro:
//   FETCH_TRAP_EN  - when defined, trap_valid/trap_vector join the redirect
//                    arbitration with the highest priority. When undefined,
//                    the trap ports are present but ignored.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pc_cur, pcadd           PC register output and its pc+4
//   npc                     next PC, loaded by the PC register every cycle
//   stall                   hazard stall (blocks accept, not redirects)
//   br_*, jmp_*, trap_*     redirect sources and their targets
//   if_req/if_addr          instruction-bus request, address = pc_cur
//   if_gnt/if_rvalid/if_rdata  bus grant and response
//   inst_valid/inst/inst_pc buffered instruction toward decode
//   id_ready                decode accepts the buffered instruction
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_cur,
    input  logic [31:0] pcadd,
    output logic [31:0] npc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        trap_valid,
    input  logic [31:0] trap_vector,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_gnt,
    input  logic        if_rvalid,
    input  logic [31:0] if_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic        load_inst;
    logic [31:0] inst_q, inst_pc_q;

    logic        redirect;
    logic [31:0] tgt;

    // Redirect arbitration
`ifdef FETCH_TRAP_EN
    always_comb begin
        redirect = trap_valid | jmp_valid | br_taken;
        if (trap_valid)     tgt = trap_vector;
        else if (jmp_valid) tgt = jmp_target;
        else                tgt = br_target;
    end
`else
    // Trap inputs are kept on the port list so both builds share one pinout.
    logic unused_trap;
    assign unused_trap = ^{trap_valid, trap_vector};

    always_comb begin
        redirect = jmp_valid | br_taken;
        if (jmp_valid) tgt = jmp_target;
        else           tgt = br_target;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            kill_q    <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            if (load_inst) begin
                inst_q    <= if_rdata;
                inst_pc_q <= pc_cur;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        load_inst = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (if_gnt) begin
                    state_d = S_WAIT;
                    kill_d  = redirect;
                end
            end
            S_WAIT: begin
                if (redirect) kill_d = 1'b1;
                if (if_rvalid) begin
                    // The response drains the outstanding request whether or
                    // not it is kept, so the kill mark is always consumed here.
                    kill_d = 1'b0;
                    if (kill_q || redirect) begin
                        state_d = S_REQ;
                    end else begin
                        state_d   = S_VALID;
                        load_inst = 1'b1;
                    end
                end
            end
            S_VALID: begin
                if (redirect || (id_ready && !stall)) state_d = S_REQ;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // Outputs
    always_comb begin
        npc        = pc_cur;
        if_req     = 1'b0;
        inst_valid = 1'b0;
        case (state_q)
            S_BOOT: npc = RESET_PC;
            S_REQ: begin
                if_req = 1'b1;
                if (redirect) npc = tgt;
            end
            S_WAIT: begin
                if (redirect) npc = tgt;
            end
            S_VALID: begin
                inst_valid = 1'b1;
                // Redirect wins over the accept in the same cycle.
                if (redirect)                npc = tgt;
                else if (id_ready && !stall) npc = pcadd;
            end
            default: npc = RESET_PC;
        endcase
    end

    assign if_addr = pc_cur;
    assign inst    = inst_q;
    assign inst_pc = inst_pc_q;

endmodule
